// File: rtl/fifo_push_arbiter_pkg.sv
// fifo_push_arbiter shared types and defaults.
// Imported by the arbiter top and its bench.
package fifo_push_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 128;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority-rotate-back one-hot picker.
// Lowest set bit at or after ptr, searched cyclically.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N),
  localparam int SW = IW + 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  pos;
  logic [SW-1:0]  sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[{1'b0, ptr} +: N];
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IW'(i);
    end
    sum = {1'b0, pos} + {1'b0, ptr};
    if (sum >= SW'(N)) sum = sum - SW'(N);
    idx = sum[IW-1:0];
    any = |req;
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push-port arbiter with packet lock,
// registered output stage and flush.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_BURST  = 8,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_push_data,
  input  logic                          fifo_push_stall,
  output logic [IW-1:0]                 grant_idx,
  output logic                          locked
);

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic [IW-1:0]   owner, owner_n;
  logic [CW-1:0]   beat_cnt, beat_cnt_n;
  logic [CW-1:0]   cnt_inc;
  logic            out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  logic            can_load;
  logic            accept;
  logic            win_valid;
  logic            win_last;
  logic [IW-1:0]   win_idx;
  logic [DATA_WIDTH-1:0] win_data;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  function automatic logic [IW-1:0] ptr_inc(
    input logic [IW-1:0] v
  );
    if (v == IW'(NUM_REQ - 1)) return '0;
    return v + IW'(1);
  endfunction

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    req_ready  = '0;
    can_load   = ~out_valid | ~fifo_push_stall;
    win_idx    = pick_idx;
    win_valid  = pick_any;
    cnt_inc    = CW'(1);
    if (state == LOCK) begin
      win_idx   = owner;
      win_valid = req_valid[owner];
      cnt_inc   = beat_cnt + CW'(1);
    end
    accept   = win_valid & can_load & ~flush;
    win_last = req_last[win_idx];
    win_data = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];

    unique case (state)
      IDLE: if (accept) req_ready = pick_gnt;
      LOCK: if (accept) req_ready[owner] = 1'b1;
    endcase

    if (flush) begin
      state_n    = IDLE;
      beat_cnt_n = '0;
    end else if (accept) begin
      owner_n = win_idx;
      // a full burst releases even mid-packet
      if (win_last || cnt_inc == CW'(MAX_BURST)) begin
        state_n    = IDLE;
        beat_cnt_n = '0;
        rr_ptr_n   = ptr_inc(win_idx);
      end else begin
        state_n    = LOCK;
        beat_cnt_n = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
    end else if (!fifo_push_stall) begin
      out_valid <= 1'b0;
    end
  end

  assign fifo_push      = out_valid;
  assign fifo_push_data = out_data;
  assign grant_idx      = owner;
  assign locked         = (state == LOCK);

endmodule
